sipo_baudrate: RTL and testbench
================================

SIPO_BAUDRATE -- requirements
Module: sipo_baudrate

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal range 2..255.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 sin  input  1  serial line, synchronous to clk; idles high.
REQ-006 dout  output  8  last correctly received byte.
REQ-007 valid  output  1  one-cycle pulse: dout updated with a new byte.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT cycles long.
REQ-011 HALF SHALL be floor(CLKS_PER_BIT/2); the bit counter SHALL be 8 bits wide and SHALL reset to 0 on every state change and after every sample.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on an edge with sin==0 (edge t0), go to START; otherwise stay.
REQ-014 START: at edge t0+HALF, sample sin; 0 goes to DATA with bit index 0; 1 is a glitch and goes to IDLE with no output pulse.
REQ-015 DATA: sample sin every CLKS_PER_BIT edges, so bit k is sampled at edge t0+HALF+(k+1)*CLKS_PER_BIT and written to shift-register bit k; after bit 7, go to STOP.
REQ-016 STOP: sample sin at edge t0+HALF+9*CLKS_PER_BIT.
- If 1: load dout from the shift register, pulse valid for one cycle, go to IDLE.
- If 0: pulse frame_err for one cycle, leave dout unchanged, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until an edge with sin==1, then go to IDLE; a held-low line (break) SHALL never start a new frame.
REQ-018 valid and frame_err SHALL be registered and SHALL never be high in the same cycle.
REQ-019 A start bit beginning on the edge immediately after valid (back-to-back frames) SHALL be detected with no lost cycles.
REQ-020 sin equal to X/Z SHALL be treated as a non-zero value in IDLE and START.
REQ-021 sin equal to X/Z SHALL be stored as sampled in DATA; the bench SHALL NOT check data bits driven X/Z.
REQ-022 busy SHALL be combinational from the state register (state != IDLE).

Reset
REQ-023 While rst==0, the block SHALL hold state=IDLE, counter=0, bit index=0, shift register=0, dout=8'h00, valid=0, frame_err=0, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with no valid or frame_err pulse.
REQ-025 After reset release, the first falling sin SHALL be treated as a start bit only if it occurs with the FSM in IDLE.

Verification (CLKS_PER_BIT=4)
REQ-026 Send byte 8'hA5 (line high before and after) -> valid high exactly one cycle at edge t0+38, dout=8'hA5, frame_err=0.
REQ-027 Send 8'h3C immediately followed by 8'hC3 -> two valid pulses 40 cycles apart, dout=8'h3C then 8'hC3.
REQ-028 Pulse sin low for 1 cycle in IDLE -> START then IDLE, no valid, no frame_err, busy high for 2 cycles.
REQ-029 Send 8'h5A with the stop bit driven 0, then hold sin low 20 cycles -> frame_err one cycle, dout keeps its prior value, FSM in WAIT_IDLE until sin returns to 1, no further frame detected.
REQ-030 Assert rst during data bit 4 of a frame -> all outputs 0 immediately, FSM in IDLE; the next full 8'hFF frame is received correctly.
REQ-031 Send a looped-back frame from the team's parallel-in serial-out baud-rate transmitter at matching CLKS_PER_BIT with din=8'h81 -> dout=8'h81, one valid pulse.

Source files
------------

// File: rtl/sipo_baudrate.sv
// sipo_baudrate: UART-style serial-in parallel-out receiver.
// Frame is one start bit (0), eight data bits LSB first and one stop bit (1),
// each bit lasting CLKS_PER_BIT clock cycles. Bits are sampled near their
// centre, HALF cycles after the falling edge of the start bit.
module sipo_baudrate #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   output logic [7:0] dout,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   // Counter values on which the START and DATA/STOP samples are taken. The
   // counter is cleared on the edge that enters a state, so the sample lands
   // exactly HALF (or CLKS_PER_BIT) edges after that entry.
   localparam logic [7:0] HALF      = 8'(CLKS_PER_BIT / 2);
   localparam logic [7:0] HALF_LAST = HALF - 8'd1;
   localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);

   logic [2:0] r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic [7:0] r_dout;
   logic       r_valid;
   logic       r_frame_err;

   logic       w_half_done;
   logic       w_bit_done;

   // Sample strobes decoded from the shared bit-timing counter.
   assign w_half_done = (r_cnt == HALF_LAST);
   assign w_bit_done  = (r_cnt == BIT_LAST);

   // Receiver FSM, bit timing, data capture and registered status pulses.
   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; a blocking = would let later statements
   // see already-updated state and skew the sample timing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the shift register is reset too, not left to power-up
         // garbage; it is only eight flops and the reset state is observable
         // through nothing but keeps simulation free of X after reset.
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_bit_idx   <= 3'd0;
         r_shift     <= 8'd0;
         r_dout      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         // Status outputs are single-cycle pulses unless set below.
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cnt     <= 8'd0;
               r_bit_idx <= 3'd0;
               // An X/Z line compares as unknown, which does not take the
               // branch, so only a definite 0 starts a frame.
               if (sin == 1'b0) begin
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_half_done) begin
                  r_cnt <= 8'd0;
                  // Start bit still low at its centre: real frame. Anything
                  // else (1, X, Z) is a glitch and is dropped silently.
                  if (sin == 1'b0) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= 3'd0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_DATA: begin
               if (w_bit_done) begin
                  r_cnt              <= 8'd0;
                  r_shift[r_bit_idx] <= sin;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= S_STOP;
                     r_bit_idx <= 3'd0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_STOP: begin
               if (w_bit_done) begin
                  r_cnt <= 8'd0;
                  if (sin == 1'b1) begin
                     r_dout  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     // Bad stop bit: keep the previous byte and wait for the
                     // line to go high so a break cannot look like a start.
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_WAIT_IDLE: begin
               r_cnt <= 8'd0;
               if (sin == 1'b1) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_cnt     <= 8'd0;
               r_bit_idx <= 3'd0;
            end
         endcase
      end
   end

   assign dout      = r_dout;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sipo_baudrate.sv
// tb_sipo_baudrate: drives serial frames into sipo_baudrate and checks every
// output on every cycle against a frame-level reference model. The model
// builds the expected output waveform from whole frames with plain arithmetic
// (sample points, busy spans, result cycle) rather than a receiver FSM.
module tb_sipo_baudrate;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic       sin;
   logic [7:0] dout;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Expected waveform, one entry per clock edge: line value driven before
   // the edge and the outputs required just after it.
   bit         q_sin[$];
   bit         q_valid[$];
   bit         q_ferr[$];
   bit         q_busy[$];
   logic [7:0] q_dout[$];
   logic [7:0] m_dout;

   sipo_baudrate #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .dout      (dout),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int cyc, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input bit s, input bit v, input bit f, input bit b);
      q_sin.push_back(s);
      q_valid.push_back(v);
      q_ferr.push_back(f);
      q_busy.push_back(b);
      q_dout.push_back(m_dout);
   endtask

   task automatic add_idle(input int n);
      repeat (n) push(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Line level at offset i (0..39) of a frame.
   function automatic bit frame_bit(input logic [7:0] data, input bit stop_ok,
                                    input int i);
      if (i < CPB) return 1'b0;
      if (i < 9 * CPB) return data[(i - CPB) / CPB];
      return stop_ok;
   endfunction

   // A whole 10-bit frame. The result appears at offset 38 (half bit plus nine
   // bit times after the start edge); busy covers offsets 0..37. With a bad
   // stop bit the line is then held low extra_low more cycles and released
   // for one cycle, and busy lasts until that release.
   task automatic add_frame(input logic [7:0] data, input bit stop_ok,
                            input int extra_low);
      int res_at;
      res_at = CPB / 2 + 9 * CPB;
      for (int i = 0; i < 10 * CPB; i++) begin
         bit v;
         bit f;
         bit b;
         v = 1'b0;
         f = 1'b0;
         b = stop_ok ? (i < res_at) : 1'b1;
         if (i == res_at) begin
            if (stop_ok) begin
               v      = 1'b1;
               m_dout = data;
            end else begin
               f = 1'b1;
            end
         end
         push(frame_bit(data, stop_ok, i), v, f, b);
      end
      if (!stop_ok) begin
         repeat (extra_low) push(1'b0, 1'b0, 1'b0, 1'b1);
         push(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Low pulse shorter than half a bit: busy for HALF edges, then idle again.
   task automatic add_glitch(input int len);
      for (int i = 0; i <= CPB / 2; i++) begin
         push((i < len) ? 1'b0 : 1'b1, 1'b0, 1'b0, (i < CPB / 2));
      end
   endtask

   task automatic play();
      for (int i = 0; i < q_sin.size(); i++) begin
         sin = q_sin[i];
         @(posedge clk);
         #1;
         check("valid", i, {7'd0, valid}, {7'd0, q_valid[i]});
         check("frame_err", i, {7'd0, frame_err}, {7'd0, q_ferr[i]});
         check("busy", i, {7'd0, busy}, {7'd0, q_busy[i]});
         check("dout", i, dout, q_dout[i]);
      end
      q_sin.delete();
      q_valid.delete();
      q_ferr.delete();
      q_busy.delete();
      q_dout.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"}, -1, dout, 8'h00);
      check({tag, "_valid"}, -1, {7'd0, valid}, 8'h00);
      check({tag, "_frame_err"}, -1, {7'd0, frame_err}, 8'h00);
      check({tag, "_busy"}, -1, {7'd0, busy}, 8'h00);
   endtask

   initial begin
      rst    = 1'b0;
      sin    = 1'b1;
      m_dout = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;

      // Directed: single byte, back-to-back pair, glitch, break after bad stop.
      add_idle(5);
      add_frame(8'hA5, 1'b1, 0);
      add_idle(3);
      add_frame(8'h3C, 1'b1, 0);
      add_frame(8'hC3, 1'b1, 0);
      add_idle(4);
      add_glitch(1);
      add_idle(2);
      add_glitch(2);
      add_frame(8'h5A, 1'b0, 20);
      add_idle(3);

      // Randomized mix of good frames, bad stop bits and glitches.
      for (int n = 0; n < 16; n++) begin
         int kind;
         kind = $urandom_range(0, 5);
         if (kind <= 2) begin
            add_frame(8'($urandom), 1'b1, 0);
         end else if (kind == 3) begin
            add_frame(8'($urandom), 1'b0, $urandom_range(0, 10));
         end else begin
            add_glitch($urandom_range(1, 2));
         end
         add_idle($urandom_range(0, 3));
      end

      // Byte as a parallel-in serial-out transmitter would emit it.
      add_frame(8'h81, 1'b1, 0);
      add_idle(3);
      play();

      // Reset in the middle of data bit 4: everything clears at once.
      add_idle(2);
      for (int i = 0; i < CPB + 4 * CPB + CPB / 2; i++) begin
         push(frame_bit(8'h96, 1'b1, i), 1'b0, 1'b0, 1'b1);
      end
      play();
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      sin    = 1'b1;
      m_dout = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("held_reset");
      rst = 1'b1;

      add_idle(2);
      add_frame(8'hFF, 1'b1, 0);
      add_idle(3);
      play();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
